// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: register-zero constant, stall
// cause encodings, mult/div tracker state and the operand-match helper.
package core_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam logic [2:0] CAUSE_NONE        = 3'd0;
   localparam logic [2:0] CAUSE_LOAD_USE    = 3'd1;
   localparam logic [2:0] CAUSE_BRANCH_ALU  = 3'd2;
   localparam logic [2:0] CAUSE_BRANCH_LOAD = 3'd3;
   localparam logic [2:0] CAUSE_MD_BUSY     = 3'd4;
   localparam logic [2:0] CAUSE_MD_ISSUE    = 3'd5;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   // True when the ID instruction reads the non-zero register r.
   function automatic logic reg_match(input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       use_rs,
                                      input logic       use_rt,
                                      input logic [4:0] r);
      return (r != REG_ZERO) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
   endfunction

endpackage

// File: rtl/hazard_md_tracker.sv
// Tracks whether the multi-cycle mult/div unit has an operation in flight.
module hazard_md_tracker
   import core_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic md_start,
   input  logic md_done,
   output logic md_busy
);

   md_state_t state;

   // IDLE/BUSY sequencing; a start while BUSY is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (md_start && !md_done) state <= BUSY;
            BUSY:    if (md_done)              state <= IDLE;
            default:                           state <= IDLE;
         endcase
      end
   end

   assign md_busy = (state == BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline interlock: detects ID-stage hazards, drives PC/IF-ID hold,
// ID/EX bubble and taken-branch flush, and counts stalled cycles.
module hazard_unit
   import core_pkg::*;
#(
   parameter int unsigned CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_is_branch,
   input  logic             id_branch_taken,
   input  logic             id_use_hilo,
   input  logic             id_is_md,
   input  logic [4:0]       ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [4:0]       mem_rd,
   input  logic             mem_mem_read,
   input  logic             md_start,
   input  logic             md_done,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic             md_busy,
   output logic [2:0]       stall_cause,
   output logic [CNT_W-1:0] stall_cnt
);

   logic md_busy_q;
   logic h_load_use, h_branch_alu, h_branch_load, h_md_busy, h_md_issue;
   logic hilo_user;
   logic stall;
   logic [2:0] cause;

   hazard_md_tracker u_md_tracker (
      .clk      (clk),
      .rst      (rst),
      .md_start (md_start),
      .md_done  (md_done),
      .md_busy  (md_busy_q)
   );

   // Hazard detection and lowest-number-wins cause encoding.
   always_comb begin
      hilo_user     = id_use_hilo || id_is_md;
      h_load_use    = ex_mem_read && reg_match(id_rs, id_rt, id_use_rs, id_use_rt, ex_rd);
      h_branch_alu  = id_is_branch && ex_reg_write && !ex_mem_read &&
                      reg_match(id_rs, id_rt, id_use_rs, id_use_rt, ex_rd);
      h_branch_load = id_is_branch && mem_mem_read &&
                      reg_match(id_rs, id_rt, id_use_rs, id_use_rt, mem_rd);
      h_md_busy     = md_busy_q && hilo_user;
      h_md_issue    = md_start && hilo_user;
      stall = h_load_use | h_branch_alu | h_branch_load | h_md_busy | h_md_issue;

      cause = CAUSE_NONE;
      if      (h_load_use)    cause = CAUSE_LOAD_USE;
      else if (h_branch_alu)  cause = CAUSE_BRANCH_ALU;
      else if (h_branch_load) cause = CAUSE_BRANCH_LOAD;
      else if (h_md_busy)     cause = CAUSE_MD_BUSY;
      else if (h_md_issue)    cause = CAUSE_MD_ISSUE;
   end

   // Outputs are gated by rst so they drop to zero asynchronously in reset.
   always_comb begin
      pc_hold     = rst && stall;
      ifid_hold   = rst && stall;
      idex_bubble = rst && stall;
      ifid_flush  = rst && id_is_branch && id_branch_taken && !stall;
      md_busy     = rst && md_busy_q;
      stall_cause = rst ? cause : CAUSE_NONE;
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (built with a 4-bit counter).
module tb_hazard_unit;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
   logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_is_branch = 1'b0;
   logic       id_branch_taken = 1'b0, id_use_hilo = 1'b0, id_is_md = 1'b0;
   logic       ex_reg_write = 1'b0, ex_mem_read = 1'b0, mem_mem_read = 1'b0;
   logic       md_start = 1'b0, md_done = 1'b0;
   logic       pc_hold, ifid_hold, idex_bubble, ifid_flush, md_busy;
   logic [2:0] stall_cause;
   logic [3:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   hazard_unit #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
      .id_use_hilo(id_use_hilo), .id_is_md(id_is_md),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
      .md_start(md_start), .md_done(md_done),
      .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
      .ifid_flush(ifid_flush), .md_busy(md_busy),
      .stall_cause(stall_cause), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
      id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_branch = 1'b0;
      id_branch_taken = 1'b0; id_use_hilo = 1'b0; id_is_md = 1'b0;
      ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_mem_read = 1'b0;
      md_start = 1'b0; md_done = 1'b0;
   endtask

   task automatic test_reset();
      // hazard inputs active while in reset: outputs must stay zero
      ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({pc_hold, ifid_hold, idex_bubble, ifid_flush, md_busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000",
                  {pc_hold, ifid_hold, idex_bubble, ifid_flush, md_busy});
      end
      checks++;
      if (stall_cause !== 3'd0 || stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: cause=%0d cnt=%0d expected 0/0", stall_cause, stall_cnt);
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
   endtask

   task automatic test_load_use();
      @(negedge clk);
      ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
      #1;
      checks++;
      if ({pc_hold, ifid_hold, idex_bubble} !== 3'b111 || stall_cause !== 3'd1) begin
         errors++;
         $display("FAIL load_use: holds=%b cause=%0d expected 111/1",
                  {pc_hold, ifid_hold, idex_bubble}, stall_cause);
      end
      checks++;
      if (stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL load_use_cnt_before: got %0d expected 0", stall_cnt);
      end
      @(posedge clk); #1;
      checks++;
      if (stall_cnt !== 4'd1) begin
         errors++;
         $display("FAIL load_use_cnt_after: got %0d expected 1", stall_cnt);
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      clear_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
      #1;
      checks++;
      if (pc_hold !== 1'b0 || stall_cause !== 3'd0) begin
         errors++;
         $display("FAIL zero_reg: hold=%b cause=%0d expected 0/0", pc_hold, stall_cause);
      end
      // matching rt that is not actually read must not stall
      ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_use_rt = 1'b0;
      #1;
      checks++;
      if (pc_hold !== 1'b0) begin
         errors++;
         $display("FAIL unused_rt: hold=%b expected 0", pc_hold);
      end
      @(posedge clk); #1;
      checks++;
      if (stall_cnt !== 4'd1) begin
         errors++;
         $display("FAIL zero_reg_cnt: got %0d expected 1", stall_cnt);
      end
   endtask

   task automatic test_branch_load();
      @(negedge clk);
      clear_inputs();
      id_is_branch = 1'b1; id_branch_taken = 1'b1; id_rs = 5'd9; id_use_rs = 1'b1;
      ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9;
      #1;
      checks++;
      if (stall_cause !== 3'd1 || pc_hold !== 1'b1 || ifid_flush !== 1'b0) begin
         errors++;
         $display("FAIL branch_load_c1: cause=%0d hold=%b flush=%b expected 1/1/0",
                  stall_cause, pc_hold, ifid_flush);
      end
      @(negedge clk);
      ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
      mem_mem_read = 1'b1; mem_rd = 5'd9;
      #1;
      checks++;
      if (stall_cause !== 3'd3 || pc_hold !== 1'b1 || ifid_flush !== 1'b0) begin
         errors++;
         $display("FAIL branch_load_c2: cause=%0d hold=%b flush=%b expected 3/1/0",
                  stall_cause, pc_hold, ifid_flush);
      end
      @(negedge clk);
      mem_mem_read = 1'b0; mem_rd = 5'd0;
      #1;
      checks++;
      if (pc_hold !== 1'b0 || stall_cause !== 3'd0 || ifid_flush !== 1'b1) begin
         errors++;
         $display("FAIL branch_load_c3: hold=%b cause=%0d flush=%b expected 0/0/1",
                  pc_hold, stall_cause, ifid_flush);
      end
      @(posedge clk); #1;
      checks++;
      if (stall_cnt !== 4'd3) begin
         errors++;
         $display("FAIL branch_load_cnt: got %0d expected 3", stall_cnt);
      end
   endtask

   task automatic test_branch_alu();
      @(negedge clk);
      clear_inputs();
      id_is_branch = 1'b1; id_branch_taken = 1'b1; id_rt = 5'd5; id_use_rt = 1'b1;
      ex_reg_write = 1'b1; ex_rd = 5'd5;
      #1;
      checks++;
      if (stall_cause !== 3'd2 || idex_bubble !== 1'b1 || ifid_flush !== 1'b0) begin
         errors++;
         $display("FAIL branch_alu_c1: cause=%0d bubble=%b flush=%b expected 2/1/0",
                  stall_cause, idex_bubble, ifid_flush);
      end
      @(negedge clk);
      ex_reg_write = 1'b0; ex_rd = 5'd0; mem_rd = 5'd5;
      #1;
      checks++;
      if (idex_bubble !== 1'b0 || ifid_flush !== 1'b1) begin
         errors++;
         $display("FAIL branch_alu_c2: bubble=%b flush=%b expected 0/1", idex_bubble, ifid_flush);
      end
      @(posedge clk); #1;
      checks++;
      if (stall_cnt !== 4'd4) begin
         errors++;
         $display("FAIL branch_alu_cnt: got %0d expected 4", stall_cnt);
      end
   endtask

   task automatic test_md();
      @(negedge clk);
      clear_inputs();
      md_start = 1'b1; id_use_hilo = 1'b1;
      #1;
      checks++;
      if (stall_cause !== 3'd5 || pc_hold !== 1'b1 || md_busy !== 1'b0) begin
         errors++;
         $display("FAIL md_issue: cause=%0d hold=%b busy=%b expected 5/1/0",
                  stall_cause, pc_hold, md_busy);
      end
      @(negedge clk);
      md_start = 1'b0;
      #1;
      checks++;
      if (stall_cause !== 3'd4 || md_busy !== 1'b1) begin
         errors++;
         $display("FAIL md_busy_c1: cause=%0d busy=%b expected 4/1", stall_cause, md_busy);
      end
      @(negedge clk);
      md_done = 1'b1;
      #1;
      checks++;
      if (stall_cause !== 3'd4 || pc_hold !== 1'b1 || md_busy !== 1'b1) begin
         errors++;
         $display("FAIL md_done_cycle: cause=%0d hold=%b busy=%b expected 4/1/1",
                  stall_cause, pc_hold, md_busy);
      end
      @(posedge clk); #1;
      checks++;
      if (md_busy !== 1'b0 || pc_hold !== 1'b0 || stall_cause !== 3'd0) begin
         errors++;
         $display("FAIL md_release: busy=%b hold=%b cause=%0d expected 0/0/0",
                  md_busy, pc_hold, stall_cause);
      end
      checks++;
      if (stall_cnt !== 4'd7) begin
         errors++;
         $display("FAIL md_cnt: got %0d expected 7", stall_cnt);
      end
      // single-cycle op: start and done together in IDLE
      @(negedge clk);
      clear_inputs();
      md_start = 1'b1; md_done = 1'b1; id_is_md = 1'b1;
      #1;
      checks++;
      if (stall_cause !== 3'd5) begin
         errors++;
         $display("FAIL md_single_cause: got %0d expected 5", stall_cause);
      end
      @(posedge clk); #1;
      checks++;
      if (md_busy !== 1'b0) begin
         errors++;
         $display("FAIL md_single_idle: busy=%b expected 0", md_busy);
      end
      // priority: load-use outranks md-issue
      @(negedge clk);
      md_done = 1'b0;
      ex_mem_read = 1'b1; ex_rd = 5'd4; id_rt = 5'd4; id_use_rt = 1'b1;
      #1;
      checks++;
      if (stall_cause !== 3'd1) begin
         errors++;
         $display("FAIL priority: cause=%0d expected 1", stall_cause);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      checks++;
      if (md_busy !== 1'b1) begin
         errors++;
         $display("FAIL md_start_busy: busy=%b expected 1", md_busy);
      end
      // start while BUSY is ignored; done returns to IDLE
      md_start = 1'b1;
      @(negedge clk);
      md_start = 1'b0;
      #1;
      checks++;
      if (md_busy !== 1'b1 || stall_cnt !== 4'd9) begin
         errors++;
         $display("FAIL md_violation: busy=%b cnt=%0d expected 1/9", md_busy, stall_cnt);
      end
      md_done = 1'b1;
      @(posedge clk); #1;
      md_done = 1'b0;
      checks++;
      if (md_busy !== 1'b0) begin
         errors++;
         $display("FAIL md_violation_done: busy=%b expected 0", md_busy);
      end
   endtask

   task automatic test_reset_mid_busy();
      @(negedge clk);
      clear_inputs();
      md_start = 1'b1;
      @(negedge clk);
      md_start = 1'b0;
      ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
      #1;
      checks++;
      if (md_busy !== 1'b1 || pc_hold !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: busy=%b hold=%b expected 1/1", md_busy, pc_hold);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({md_busy, pc_hold, ifid_hold, idex_bubble, ifid_flush} !== 5'b0 ||
          stall_cause !== 3'd0 || stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL async_reset: outs=%b cause=%0d cnt=%0d expected 00000/0/0",
                  {md_busy, pc_hold, ifid_hold, idex_bubble, ifid_flush}, stall_cause, stall_cnt);
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      md_done = 1'b1;
      @(posedge clk); #1;
      md_done = 1'b0;
      checks++;
      if (md_busy !== 1'b0 || stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL post_reset: busy=%b cnt=%0d expected 0/0", md_busy, stall_cnt);
      end
   endtask

   task automatic test_saturation();
      @(negedge clk);
      clear_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd12; id_rt = 5'd12; id_use_rt = 1'b1;
      for (int i = 0; i < 15; i++) @(posedge clk);
      #1;
      checks++;
      if (stall_cnt !== 4'd15) begin
         errors++;
         $display("FAIL sat_reach: got %0d expected 15", stall_cnt);
      end
      for (int i = 0; i < 5; i++) @(posedge clk);
      #1;
      checks++;
      if (stall_cnt !== 4'd15) begin
         errors++;
         $display("FAIL sat_hold: got %0d expected 15", stall_cnt);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_reg();
      test_branch_load();
      test_branch_alu();
      test_md();
      test_reset_mid_busy();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
